// File: rtl/dmem_lsu.sv
// Load/store initiator for the DMem word memory: byte/half/word accesses, RMW sub-word stores.
// Optional LSU_ALIGN_CHECK_EN: misaligned halves/words become errors instead of being force-aligned.
module dmem_lsu #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          Ewr,
  output logic          Erd,
  output logic [AW-1:0] Addr,
  output logic [31:0]   RDir,
  input  logic [31:0]   MOut
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // RD    | Erd asserted, MOut captured at end of cycle
  // MRG   | old word merged with store lanes, no strobes
  // WR    | Ewr asserted with merged or full word
  // RESP  | one-cycle rsp_valid pulse
  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t        state_q, state_d;
  logic          op_wr_q;
  logic [1:0]    op_size_q;
  logic          op_sgn_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   old_q;

  logic          ewr_d, erd_d, rsp_valid_d, rsp_err_d, accept;
  logic [AW-1:0] addr_d;
  logic [31:0]   rdir_d, rsp_rdata_d;

  logic [AW-1:0] idx_in;
  logic [1:0]    lane_in;
  logic          misalign_err;
  logic          req_err;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (size)
      SZ_BYTE: lane_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: lane_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: lane_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] mask;
    mask = (size == SZ_BYTE) ? 32'h0000_00ff : 32'h0000_ffff;
    mask = mask << {lane, 3'b000};
    lane_merge = (old & ~mask) | ((data << {lane, 3'b000}) & mask);
  endfunction

  always_comb begin
    idx_in       = req_addr >> 2;
    lane_in      = req_addr[1:0];
    misalign_err = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misalign_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SZ_HALF) lane_in[0] = 1'b0;
    if (req_size == SZ_WORD) lane_in    = 2'b00;
`endif
    req_err = (idx_in >= AW'(DEPTH)) || (req_size == SZ_RSVD) || misalign_err;
  end

  // Strobes and response are computed for the next state and registered with it.
  always_comb begin
    state_d     = state_q;
    ewr_d       = 1'b0;
    erd_d       = 1'b0;
    addr_d      = '0;
    rdir_d      = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_wr && (req_size == SZ_WORD)) begin
            state_d = WR;
            ewr_d   = 1'b1;
            addr_d  = idx_in;
            rdir_d  = req_wdata;
          end else begin
            state_d = RD;
            erd_d   = 1'b1;
            addr_d  = idx_in;
          end
        end
      end
      RD: begin
        if (op_wr_q) begin
          state_d = MRG;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = lane_extract(MOut, lane_q, op_size_q, op_sgn_q);
        end
      end
      MRG: begin
        state_d = WR;
        ewr_d   = 1'b1;
        addr_d  = idx_q;
        rdir_d  = lane_merge(old_q, wdata_q, lane_q, op_size_q);
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      Ewr       <= 1'b0;
      Erd       <= 1'b0;
      Addr      <= '0;
      RDir      <= '0;
      op_wr_q   <= 1'b0;
      op_size_q <= '0;
      op_sgn_q  <= 1'b0;
      lane_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      old_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      Ewr       <= ewr_d;
      Erd       <= erd_d;
      Addr      <= addr_d;
      RDir      <= rdir_d;
      if (accept) begin
        op_wr_q   <= req_wr;
        op_size_q <= req_size;
        op_sgn_q  <= req_signed;
        lane_q    <= lane_in;
        idx_q     <= idx_in;
        wdata_q   <= req_wdata;
      end
      if (state_q == RD) old_q <= MOut;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized requests against a
// word-array reference model; honours LSU_ALIGN_CHECK_EN the same way as the design.
module tb_dmem_lsu;
  localparam int DEPTH = 32;
  localparam int AW    = 32;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_wr, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err, busy, Ewr, Erd;
  logic [31:0]   rsp_rdata, RDir, MOut;
  logic [AW-1:0] Addr;

  dmem_lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .Ewr(Ewr), .Erd(Erd), .Addr(Addr), .RDir(RDir), .MOut(MOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMem behavioural memory
  logic [31:0] mem [DEPTH];
  logic        mem_clr;
  assign MOut = (Addr < DEPTH) ? mem[Addr[4:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (Ewr && (Addr < DEPTH)) begin
      mem[Addr[4:0]] <= RDir;
    end
  end

  int          ewr_cnt = 0, erd_cnt = 0, both_cnt = 0, idle_viol = 0, rsp_cnt = 0;
  logic [31:0] ewr_addr = 0, ewr_data = 0, erd_addr = 0;
  always @(negedge clk) begin
    if (Ewr) begin ewr_cnt++; ewr_addr = Addr; ewr_data = RDir; end
    if (Erd) begin erd_cnt++; erd_addr = Addr; end
    if (Ewr && Erd) both_cnt++;
    if (!Ewr && !Erd && (Addr != 0 || RDir != 0)) idle_viol++;
    if (rsp_valid) rsp_cnt++;
  end

  logic [31:0] rmem [DEPTH];
  int          checks = 0, errors = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] widx, a_eff, word, v, m, newword, exp_rd;
    logic        mis, err;
    int          sh, lat, exp_ewr, exp_erd, cyc;
    int          e0, r0, b0, iv0;
    widx  = addr >> 2;
    a_eff = addr;
    mis   = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
    if (size == 2'd1) a_eff[0]   = 1'b0;
    if (size == 2'd2) a_eff[1:0] = 2'd0;
`endif
    err     = (widx >= DEPTH) || (size == 2'd3) || mis;
    sh      = 8 * int'(a_eff[1:0]);
    exp_rd  = 32'h0;
    exp_ewr = 0;
    exp_erd = 0;
    newword = 32'h0;
    if (err) begin
      lat = 1;
    end else begin
      word = rmem[widx[4:0]];
      if (!wr) begin
        lat = 2; exp_erd = 1;
        if (size == 2'd0) begin
          v = (word >> sh) & 32'hff;
          if (sgn && v[7]) v = v | 32'hffff_ff00;
        end else if (size == 2'd1) begin
          v = (word >> sh) & 32'hffff;
          if (sgn && v[15]) v = v | 32'hffff_0000;
        end else begin
          v = word;
        end
        exp_rd = v;
      end else if (size == 2'd2) begin
        lat = 2; exp_ewr = 1; newword = wd;
      end else begin
        lat = 4; exp_ewr = 1; exp_erd = 1;
        m = (size == 2'd0) ? 32'hff : 32'hffff;
        newword = (word & ~(m << sh)) | ((wd & m) << sh);
      end
    end
    e0 = ewr_cnt; r0 = erd_cnt; b0 = both_cnt; iv0 = idle_viol;

    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wr = $urandom; req_size = 2'($urandom); req_signed = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(rsp_err), 32'(err));
    chk({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
    last_rdata = rsp_rdata;
    @(negedge clk);
    chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".idle"}, {30'd0, req_ready, busy}, 32'b10);
    chk({tag, ".ewr_cnt"}, 32'(ewr_cnt - e0), 32'(exp_ewr));
    chk({tag, ".erd_cnt"}, 32'(erd_cnt - r0), 32'(exp_erd));
    chk({tag, ".strobe_rules"}, 32'((both_cnt - b0) + (idle_viol - iv0)), 32'd0);
    if (exp_erd != 0) chk({tag, ".erd_addr"}, erd_addr, widx);
    if (exp_ewr != 0) begin
      chk({tag, ".ewr_addr"}, ewr_addr, widx);
      chk({tag, ".ewr_data"}, ewr_data, newword);
      rmem[widx[4:0]] = newword;
    end
  endtask

  initial begin
    int e0, p0;
    logic [1:0] sz;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_clr = 1'b1;
    for (int i = 0; i < DEPTH; i++) rmem[i] = 32'h0;
    @(posedge clk); @(posedge clk);
    #1 mem_clr = 1'b0;
    chk("rst.outs", {26'd0, rsp_valid, rsp_err, busy, Ewr, Erd, req_ready}, 32'b000001);
    chk("rst.data", rsp_rdata | Addr | RDir, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_req("sw08", 1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF);
    chk("sw08.rdir", ewr_data, 32'hDEAD_BEEF);
    chk("sw08.addr", ewr_addr, 32'd2);
    run_req("lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    chk("lw08.val", last_rdata, 32'hDEAD_BEEF);

    run_req("sb13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5);
    chk("sb13.rdir", ewr_data, 32'hA500_0000);

    run_req("sw04", 1'b1, 2'd2, 1'b0, 32'h04, 32'h80FF_7F01);
    run_req("lbs06", 1'b0, 2'd0, 1'b1, 32'h06, 32'h0);
    chk("lbs06.val", last_rdata, 32'hFFFF_FFFF);
    run_req("lhu06", 1'b0, 2'd1, 1'b0, 32'h06, 32'h0);
    chk("lhu06.val", last_rdata, 32'h0000_80FF);
    run_req("lbs04", 1'b0, 2'd0, 1'b1, 32'h04, 32'h0);
    chk("lbs04.val", last_rdata, 32'h0000_0001);

    run_req("lw80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    run_req("rsvd00", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
    run_req("sw80", 1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678);
    run_req("sw7c", 1'b1, 2'd2, 1'b0, 32'h7C, 32'hCAFE_F00D);
    run_req("sh7e", 1'b1, 2'd1, 1'b0, 32'h7E, 32'h0000_1357);

    run_req("lh05", 1'b0, 2'd1, 1'b0, 32'h05, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lh05.val", last_rdata, 32'h0);
`else
    chk("lh05.val", last_rdata, 32'h0000_7F01);
`endif

    // Reset during MRG of a byte store to index 8
    e0 = ewr_cnt; p0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmrg.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmrg.outs", {26'd0, rsp_valid, rsp_err, busy, Ewr, Erd, req_ready}, 32'b000001);
    chk("rstmrg.data", Addr | RDir | rsp_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmrg.no_ewr", 32'(ewr_cnt - e0), 32'd0);
    chk("rstmrg.no_rsp", 32'(rsp_cnt - p0), 32'd0);
    chk("rstmrg.mem", mem[8], rmem[8]);

    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, DEPTH * 4 + 11);
      run_req("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < DEPTH; i++) chk("mem_final", mem[i], rmem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
